cpu_bus_master: RTL and testbench

- Clocked master for the multiplexed AD bus, driven by a single-request CPU port.
- Accepts one CPU access at a time and encodes byte-lane write strobes into the tm1n/tm0n size code and the low address bits.
- Drives an address cycle, then a data cycle; holds the data cycle until the target signals ready, or until a wait-state timeout expires.
- Returns read data, a done pulse and an error flag; data width is parametrised for 32- or 64-bit buses.

---
 rtl/cpu_bus_master_if.sv | 39 +++
 rtl/cpu_bus_master.sv | 176 +++++++++++++++++
 tb/tb_cpu_bus_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_master_if.sv
// CPU request port and multiplexed AD bus signals of cpu_bus_master.
// The master modport is the bus master's view; slave is the opposite side.
interface cpu_bus_master_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int NB = DW / 8;

   // CPU side
   logic          cpu_req;
   logic [NB-1:0] cpu_write;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_busy;
   logic          cpu_ack;
   logic          cpu_error;
   logic [DW-1:0] cpu_rdata;

   // AD bus side
   logic [DW-1:0] bus_ad_o;
   logic          bus_ad_oe;
   logic [DW-1:0] bus_ad_i;
   logic          bus_adrcyn_o;
   logic          bus_tm1n_o;
   logic          bus_tm0n_o;
   logic          bus_rdyn_i;

   modport master (
      input  cpu_req, cpu_write, cpu_addr, cpu_wdata, bus_ad_i, bus_rdyn_i,
      output cpu_busy, cpu_ack, cpu_error, cpu_rdata,
             bus_ad_o, bus_ad_oe, bus_adrcyn_o, bus_tm1n_o, bus_tm0n_o
   );

   modport slave (
      output cpu_req, cpu_write, cpu_addr, cpu_wdata, bus_ad_i, bus_rdyn_i,
      input  cpu_busy, cpu_ack, cpu_error, cpu_rdata,
             bus_ad_o, bus_ad_oe, bus_adrcyn_o, bus_tm1n_o, bus_tm0n_o
   );
endinterface

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: turns one CPU access at a time into an address cycle
// followed by a data cycle on the multiplexed AD bus. Byte-lane strobes are
// folded into the tm1n/tm0n size code and the low address bits. The data
// cycle ends on target ready or after TIMEOUT wait states (error).
module cpu_bus_master #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TOW     = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   cpu_bus_master_if.master bus
);
   localparam int NB = DW / 8;
   localparam int LB = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   typedef struct packed {
      logic          legal;
      logic          tm1n;
      logic          tm0n;
      logic [LB-1:0] low;
   } enc_t;

   // Classify a strobe pattern: read, single lane, aligned power-of-two
   // group, full width, or illegal.
   function automatic enc_t encode(input logic [NB-1:0] strb);
      enc_t          e;
      int            cnt;
      int            first;
      logic [NB-1:0] group;
      e     = '{legal: 1'b0, tm1n: 1'b1, tm0n: 1'b1, low: '0};
      cnt   = 0;
      first = 0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (strb[i]) begin
            cnt   = cnt + 1;
            first = i;
         end
      end
      // contiguous run of cnt lanes starting at the lowest set lane
      group = NB'(((1 << cnt) - 1) << first);
      if (cnt == 0) begin
         e.legal = 1'b1;
      end else if (cnt == 1) begin
         e.legal = 1'b1;
         e.tm1n  = 1'b0;
         e.tm0n  = 1'b0;
         e.low   = LB'(first);
      end else if (cnt == NB) begin
         e.legal = 1'b1;
         e.tm1n  = 1'b0;
      end else if (((cnt & (cnt - 1)) == 0) && (strb == group) && ((first % cnt) == 0)) begin
         // (g << s) equals the first lane index; (1 << (s-1)) is cnt/2
         e.legal = 1'b1;
         e.tm1n  = 1'b0;
         e.low   = LB'(first | (cnt >> 1));
      end
      return e;
   endfunction

   state_t        state_reg;
   logic [TOW-1:0] cnt_reg;
   logic          is_write_reg;
   logic [DW-1:0] wdata_reg;
   logic          busy_reg;
   logic          ack_reg;
   logic          error_reg;
   logic [DW-1:0] rdata_reg;
   logic [DW-1:0] ad_o_reg;
   logic          ad_oe_reg;
   logic          adrcyn_reg;
   logic          tm1n_reg;
   logic          tm0n_reg;

   enc_t          enc;
   logic [AW-1:0] addr_enc;
   logic          unused_addr_lsb;

   // Decode the incoming strobes every cycle; only used on acceptance.
   always_comb begin
      enc = encode(bus.cpu_write);
   end

   // Low address bits on the bus come from the strobe encoding instead.
   assign addr_enc        = {bus.cpu_addr[AW-1:LB], enc.low};
   assign unused_addr_lsb = ^bus.cpu_addr[LB-1:0];

   // Transaction sequencer; every bus and CPU output is a register here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= '0;
         is_write_reg <= 1'b0;
         wdata_reg    <= '0;
         busy_reg     <= 1'b0;
         ack_reg      <= 1'b0;
         error_reg    <= 1'b0;
         rdata_reg    <= '0;
         ad_o_reg     <= '0;
         ad_oe_reg    <= 1'b0;
         adrcyn_reg   <= 1'b1;
         tm1n_reg     <= 1'b1;
         tm0n_reg     <= 1'b1;
      end else begin
         ack_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               error_reg <= 1'b0;
               if (bus.cpu_req) begin
                  busy_reg <= 1'b1;
                  if (enc.legal) begin
                     state_reg    <= S_ADDR;
                     is_write_reg <= |bus.cpu_write;
                     wdata_reg    <= bus.cpu_wdata;
                     adrcyn_reg   <= 1'b0;
                     ad_oe_reg    <= 1'b1;
                     ad_o_reg     <= DW'(addr_enc);
                     tm1n_reg     <= enc.tm1n;
                     tm0n_reg     <= enc.tm0n;
                  end else begin
                     // illegal strobe: answer straight away, bus untouched
                     state_reg <= S_RESP;
                     ack_reg   <= 1'b1;
                     error_reg <= 1'b1;
                  end
               end
            end
            S_ADDR: begin
               state_reg  <= S_DATA;
               cnt_reg    <= '0;
               adrcyn_reg <= 1'b1;
               ad_oe_reg  <= is_write_reg;
               ad_o_reg   <= is_write_reg ? wdata_reg : '0;
            end
            S_DATA: begin
               if (!bus.bus_rdyn_i || (cnt_reg == TOW'(TIMEOUT))) begin
                  // ready wins over a timeout in the same cycle
                  if (!bus.bus_rdyn_i && !is_write_reg) begin
                     rdata_reg <= bus.bus_ad_i;
                  end
                  state_reg <= S_RESP;
                  ack_reg   <= 1'b1;
                  error_reg <= bus.bus_rdyn_i;
                  ad_oe_reg <= 1'b0;
                  ad_o_reg  <= '0;
                  tm1n_reg  <= 1'b1;
                  tm0n_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_RESP: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
               error_reg <= 1'b0;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_busy     = busy_reg;
   assign bus.cpu_ack      = ack_reg;
   assign bus.cpu_error    = error_reg;
   assign bus.cpu_rdata    = rdata_reg;
   assign bus.bus_ad_o     = ad_o_reg;
   assign bus.bus_ad_oe    = ad_oe_reg;
   assign bus.bus_adrcyn_o = adrcyn_reg;
   assign bus.bus_tm1n_o   = tm1n_reg;
   assign bus.bus_tm0n_o   = tm0n_reg;
endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: a 32-bit instance (TIMEOUT=4) and a 64-bit
// instance (TIMEOUT=6) share clock, reset and a common stimulus driver.
module tb_cpu_bus_master;
   localparam int T32 = 4;
   localparam int T64 = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cpu_bus_master_if #(.AW(32), .DW(32)) if32 ();
   cpu_bus_master_if #(.AW(32), .DW(64)) if64 ();

   cpu_bus_master #(.AW(32), .DW(32), .TOW(8), .TIMEOUT(T32)) d32 (.clk(clk), .rst_n(rst_n), .bus(if32));
   cpu_bus_master #(.AW(32), .DW(64), .TOW(8), .TIMEOUT(T64)) d64 (.clk(clk), .rst_n(rst_n), .bus(if64));

   // common driver, steered to one instance by use64
   logic        use64 = 1'b0;
   logic        req = 1'b0;
   logic [7:0]  strb_d = '0;
   logic [31:0] addr_d = '0;
   logic [63:0] wdata_d = '0;
   logic [63:0] ad_i = '0;
   logic        rdyn = 1'b1;

   assign if32.cpu_req    = req && !use64;
   assign if32.cpu_write  = strb_d[3:0];
   assign if32.cpu_addr   = addr_d;
   assign if32.cpu_wdata  = wdata_d[31:0];
   assign if32.bus_ad_i   = ad_i[31:0];
   assign if32.bus_rdyn_i = rdyn;
   assign if64.cpu_req    = req && use64;
   assign if64.cpu_write  = strb_d;
   assign if64.cpu_addr   = addr_d;
   assign if64.cpu_wdata  = wdata_d;
   assign if64.bus_ad_i   = ad_i;
   assign if64.bus_rdyn_i = rdyn;

   // monitor view of the selected instance
   wire [63:0] m_ad_o   = use64 ? if64.bus_ad_o  : {32'h0, if32.bus_ad_o};
   wire [63:0] m_rdata  = use64 ? if64.cpu_rdata : {32'h0, if32.cpu_rdata};
   wire        m_oe     = use64 ? if64.bus_ad_oe : if32.bus_ad_oe;
   wire        m_adrcyn = use64 ? if64.bus_adrcyn_o : if32.bus_adrcyn_o;
   wire        m_tm1n   = use64 ? if64.bus_tm1n_o : if32.bus_tm1n_o;
   wire        m_tm0n   = use64 ? if64.bus_tm0n_o : if32.bus_tm0n_o;
   wire        m_busy   = use64 ? if64.cpu_busy  : if32.cpu_busy;
   wire        m_ack    = use64 ? if64.cpu_ack   : if32.cpu_ack;
   wire        m_err    = use64 ? if64.cpu_error : if32.cpu_error;

   int checks = 0;
   int errors = 0;
   int txn_no = 0;
   logic [63:0] last_rd32 = '0;
   logic [63:0] last_rd64 = '0;

   typedef struct {
      logic        is64;
      logic [7:0]  strb;
      logic [31:0] addr;
      logic [63:0] wdata;
      int          rdy_wait;   // DATA cycle index of ready, -1 = never
      logic [63:0] rd_val;
      logic        legal;
      logic [1:0]  tm;         // {tm1n, tm0n}
      logic [2:0]  low;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic is64, input logic [7:0] strb, input logic [31:0] addr,
                               input logic [63:0] wdata, input int rdy_wait, input logic [63:0] rd_val,
                               input logic legal, input logic [1:0] tm, input logic [2:0] low);
      vec_t v;
      v.is64 = is64; v.strb = strb; v.addr = addr; v.wdata = wdata; v.rdy_wait = rdy_wait;
      v.rd_val = rd_val; v.legal = legal; v.tm = tm; v.low = low;
      return v;
   endfunction

   // Reference encoding: enumerate every legal aligned group of 2^s lanes
   // and look the strobe up. Returns {legal, tm1n, tm0n, low[2:0]}.
   function automatic logic [5:0] ref_encode(input logic [7:0] strb, input int nb);
      int         lb;
      int         w;
      logic [7:0] pat;
      lb = (nb == 8) ? 3 : 2;
      if (strb == 8'h00) return {1'b1, 2'b11, 3'd0};
      for (int s = 0; s <= lb; s++) begin
         w = 1 << s;
         for (int g = 0; g < nb / w; g++) begin
            pat = 8'(((1 << w) - 1) << (g * w));
            if (strb == pat) begin
               if (s == 0)  return {1'b1, 2'b00, 3'(g)};
               if (s == lb) return {1'b1, 2'b01, 3'd0};
               return {1'b1, 2'b01, 3'((g << s) | (1 << (s - 1)))};
            end
         end
      end
      return {1'b0, 2'b11, 3'd0};
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_ctl"}, {57'h0, m_adrcyn, m_tm1n, m_tm0n, m_oe, m_busy, m_ack, m_err}, 64'h70);
      check({tag, "_ad_o"}, m_ad_o, 64'h0);
      check({tag, "_rdata"}, m_rdata, 64'h0);
   endtask

   // One CPU access: drive the request, play the target side, record what
   // the master did cycle by cycle, compare with the expected transaction.
   task automatic txn(input vec_t v, input logic poke);
      int          t, nb, exp_ack_n, n, ack_n, adr_cycles;
      logic        is_wr, exp_err, got_err, got_busy1, got_a_oe, got_d_oe, got_oe_r;
      logic [1:0]  got_tm_a, got_tm_d, got_tm_r;
      logic [3:0]  bad;
      logic [63:0] exp_addr, exp_rdata, exp_dad, got_addr, got_d_ad, got_rdata;
      t  = v.is64 ? T64 : T32;
      nb = v.is64 ? 8 : 4;
      is_wr = (v.strb != 8'h00);
      if (!v.legal) begin
         exp_ack_n = 1; exp_err = 1'b1;
      end else if (v.rdy_wait >= 0 && v.rdy_wait <= t) begin
         exp_ack_n = 3 + v.rdy_wait; exp_err = 1'b0;
      end else begin
         exp_ack_n = 3 + t; exp_err = 1'b1;
      end
      exp_rdata = v.is64 ? last_rd64 : last_rd32;
      if (v.legal && !exp_err && !is_wr) exp_rdata = v.is64 ? v.rd_val : {32'h0, v.rd_val[31:0]};
      exp_addr = {32'h0, v.addr & ~32'(nb - 1)} | 64'(v.low);
      exp_dad  = !is_wr ? 64'h0 : (v.is64 ? v.wdata : {32'h0, v.wdata[31:0]});

      ack_n = -1; adr_cycles = 0; got_err = 1'b0; got_busy1 = 1'b0;
      got_a_oe = 1'b0; got_d_oe = 1'b0; got_oe_r = 1'b1;
      got_tm_a = 2'b11; got_tm_d = 2'b11; got_tm_r = 2'b00;
      got_addr = '0; got_d_ad = '0; got_rdata = '0;

      @(negedge clk);
      use64 = v.is64; req = 1'b1; strb_d = v.strb; addr_d = v.addr; wdata_d = v.wdata;
      rdyn = 1'b1; ad_i = ~v.rd_val;
      n = 0;
      while (ack_n < 0 && n < 40) begin
         @(negedge clk);
         n++;
         req = poke && (n == 2);   // second request while busy must be ignored
         if (n == 1) got_busy1 = m_busy;
         if (!m_adrcyn) begin
            adr_cycles++; got_addr = m_ad_o; got_tm_a = {m_tm1n, m_tm0n}; got_a_oe = m_oe;
         end
         if (n == 2) begin
            got_d_oe = m_oe; got_d_ad = m_ad_o; got_tm_d = {m_tm1n, m_tm0n};
         end
         if (m_ack) begin
            ack_n = n; got_err = m_err; got_rdata = m_rdata;
            got_tm_r = {m_tm1n, m_tm0n}; got_oe_r = m_oe;
         end
         rdyn = !(n >= 2 && (n - 2) == v.rdy_wait);
         ad_i = rdyn ? ~v.rd_val : v.rd_val;
      end
      req = 1'b0; rdyn = 1'b1;

      check("ack_seen", 64'(ack_n >= 0), 64'h1);
      check("ack_latency", 64'(ack_n), 64'(exp_ack_n));
      check("error", 64'(got_err), 64'(exp_err));
      check("rdata", got_rdata, exp_rdata);
      check("busy_after_req", 64'(got_busy1), 64'h1);
      check("resp_tm_oe", {61'h0, got_tm_r, got_oe_r}, 64'h6);
      if (v.legal) begin
         check("addr_cycles", 64'(adr_cycles), 64'h1);
         check("addr_value", got_addr, exp_addr);
         check("addr_tm_oe", {61'h0, got_tm_a, got_a_oe}, {61'h0, v.tm, 1'b1});
         check("data_tm_held", 64'(got_tm_d), 64'(v.tm));
         check("data_oe", 64'(got_d_oe), 64'(is_wr));
         check("data_ad_o", got_d_ad, exp_dad);
      end else begin
         check("no_addr_cycle", 64'(adr_cycles), 64'h0);
      end
      bad = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bad = bad | {m_ack, !m_adrcyn, m_busy, m_oe};
      end
      check("idle_after", 64'(bad), 64'h0);

      if (v.is64) last_rd64 = exp_rdata; else last_rd32 = exp_rdata;
      txn_no++;
      $display("txn %0d dw=%0d strb=%b addr=%h wr=%0d wait=%0d poke=%0d ack@%0d err=%0d rdata=%h",
               txn_no, v.is64 ? 64 : 32, v.strb, v.addr, is_wr, v.rdy_wait, poke, ack_n, got_err, got_rdata);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t        v;
      int          nb, t, s, w, g, bad_cnt;
      logic [5:0]  e;
      logic [7:0]  strb;

      // directed vectors: {dw64, strobe, addr, wdata, ready at, bus data, legal, tm, low}
      vecs.push_back(mk(0, 8'h00, 32'h1000_0007, 64'h0, 1, 64'hDEAD_BEEF, 1, 2'b11, 3'd0));
      vecs.push_back(mk(0, 8'h04, 32'h0000_0020, 64'hA1B2_C3D4, 0, 64'h0, 1, 2'b00, 3'd2));
      vecs.push_back(mk(0, 8'h0C, 32'h0000_0020, 64'h5566_7788, 2, 64'h0, 1, 2'b01, 3'd3));
      vecs.push_back(mk(0, 8'h0F, 32'h0000_0020, 64'hCAFE_F00D, 0, 64'h0, 1, 2'b01, 3'd0));
      vecs.push_back(mk(0, 8'h05, 32'h0000_0020, 64'h1, 0, 64'h0, 0, 2'b11, 3'd0));
      vecs.push_back(mk(0, 8'h00, 32'h0000_0100, 64'h0, -1, 64'h1234_5678, 1, 2'b11, 3'd0));
      vecs.push_back(mk(0, 8'h00, 32'h0000_0104, 64'h0, T32, 64'h0BAD_F00D, 1, 2'b11, 3'd0));
      vecs.push_back(mk(0, 8'h01, 32'h0000_0033, 64'h11, 0, 64'h0, 1, 2'b00, 3'd0));
      vecs.push_back(mk(0, 8'h02, 32'h0000_0030, 64'h22, 1, 64'h0, 1, 2'b00, 3'd1));
      vecs.push_back(mk(0, 8'h08, 32'h0000_0030, 64'h33, 0, 64'h0, 1, 2'b00, 3'd3));
      vecs.push_back(mk(0, 8'h03, 32'h0000_0030, 64'h44, 0, 64'h0, 1, 2'b01, 3'd1));
      vecs.push_back(mk(0, 8'h06, 32'h0000_0030, 64'h55, 0, 64'h0, 0, 2'b11, 3'd0));
      vecs.push_back(mk(1, 8'h30, 32'h2000_0008, 64'h0123_4567_89AB_CDEF, 1, 64'h0, 1, 2'b01, 3'd5));
      vecs.push_back(mk(1, 8'hF0, 32'h2000_0008, 64'h1111_2222_3333_4444, 0, 64'h0, 1, 2'b01, 3'd6));
      vecs.push_back(mk(1, 8'hFF, 32'h2000_000F, 64'h5555_6666_7777_8888, 0, 64'h0, 1, 2'b01, 3'd0));
      vecs.push_back(mk(1, 8'h18, 32'h2000_0008, 64'h0, 0, 64'h0, 0, 2'b11, 3'd0));
      vecs.push_back(mk(1, 8'h00, 32'h2000_0010, 64'h0, 3, 64'hFEDC_BA98_7654_3210, 1, 2'b11, 3'd0));
      vecs.push_back(mk(1, 8'h00, 32'h2000_0018, 64'h0, -1, 64'h0F0F_0F0F_0F0F_0F0F, 1, 2'b11, 3'd0));
      vecs.push_back(mk(1, 8'h0C, 32'h2000_0020, 64'h9999_AAAA_BBBB_CCCC, 0, 64'h0, 1, 2'b01, 3'd3));
      vecs.push_back(mk(1, 8'h80, 32'h2000_0020, 64'hDDDD_EEEE_FFFF_0000, 0, 64'h0, 1, 2'b00, 3'd7));

      // reset values on both instances
      repeat (3) @(negedge clk);
      use64 = 1'b0; #1; check_reset_vals("reset32");
      use64 = 1'b1; #1; check_reset_vals("reset64");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         txn(vecs[i], i[0]);
      end

      // reset during DATA, a request while reset is held, then normal use
      @(negedge clk);
      use64 = 1'b0; req = 1'b1; strb_d = 8'h00; addr_d = 32'h40; rdyn = 1'b1;
      @(negedge clk); req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      last_rd32 = '0; last_rd64 = '0;
      @(negedge clk); req = 1'b1;
      @(negedge clk); req = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      bad_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (m_ack || !m_adrcyn || m_busy) bad_cnt++;
      end
      check("quiet_after_reset", 64'(bad_cnt), 64'h0);
      $display("reset sequence: reset in DATA, request during reset, %0d bad idle cycles", bad_cnt);
      txn(mk(0, 8'h0F, 32'h0000_0050, 64'h7777_8888, 0, 64'h0, 1, 2'b01, 3'd0), 1'b0);

      // randomized accesses checked against the enumerating reference model
      for (int r = 0; r < 60; r++) begin
         v.is64 = 1'($urandom_range(0, 1));
         nb = v.is64 ? 8 : 4;
         t  = v.is64 ? T64 : T32;
         if ($urandom_range(0, 1) == 0) begin
            strb = 8'($urandom);
         end else begin
            s = $urandom_range(0, v.is64 ? 3 : 2);
            w = 1 << s;
            g = $urandom_range(0, nb / w - 1);
            strb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(((1 << w) - 1) << (g * w));
         end
         if (!v.is64) strb = strb & 8'h0F;
         e = ref_encode(strb, nb);
         v.strb = strb;
         v.addr = $urandom;
         v.wdata = {$urandom, $urandom};
         v.rd_val = {$urandom, $urandom};
         v.rdy_wait = $urandom_range(0, t + 2);
         if (v.rdy_wait > t) v.rdy_wait = -1;
         v.legal = e[5];
         v.tm = e[4:3];
         v.low = e[2:0];
         txn(v, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
